// File: rtl/deco_salida_picoblaze.sv
// PicoBlaze output-port decoder that issues RTC read/write starts; ERR_FLAG_EN adds a sticky error_cmd flag.
// Latency: register writes and start pulses appear one cycle after write_strobe.
// Backpressure: while ocupado=1, register writes and commands are dropped.
module deco_salida_picoblaze (
    input  logic       clk,
    input  logic       rst,
    input  logic       write_strobe,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       listo_lee,
    input  logic       listo_escribe,
    output logic [7:0] RG1_out,
    output logic [7:0] RG2_out,
    output logic [7:0] RG3_out,
    output logic [7:0] direccion,
    output logic       inicia_lee,
    output logic       inicia_escribe,
    output logic       ocupado
`ifdef ERR_FLAG_EN
    ,
    output logic       error_cmd
`endif
);

    typedef enum logic [1:0] {REPOSO, LEYENDO, ESCRIBIENDO} estado_t;

    estado_t estado, estado_sig;
    logic    wr_cmd;
    logic    inicia_lee_sig, inicia_escribe_sig;

    assign wr_cmd  = write_strobe && (port_id == 8'h05);
    assign ocupado = (estado != REPOSO);

    always_comb begin
        estado_sig         = estado;
        inicia_lee_sig     = 1'b0;
        inicia_escribe_sig = 1'b0;
        case (estado)
            REPOSO: begin
                if (wr_cmd && out_port[1:0] == 2'b01) begin
                    estado_sig     = LEYENDO;
                    inicia_lee_sig = 1'b1;
                end else if (wr_cmd && out_port[1:0] == 2'b10) begin
                    estado_sig         = ESCRIBIENDO;
                    inicia_escribe_sig = 1'b1;
                end
            end
            LEYENDO: begin
                if (listo_lee)
                    estado_sig = REPOSO;
            end
            ESCRIBIENDO: begin
                if (listo_escribe)
                    estado_sig = REPOSO;
            end
            default: estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado         <= REPOSO;
            inicia_lee     <= 1'b0;
            inicia_escribe <= 1'b0;
        end else begin
            estado         <= estado_sig;
            inicia_lee     <= inicia_lee_sig;
            inicia_escribe <= inicia_escribe_sig;
        end
    end

    // Data/address are frozen for the whole transaction the sequencer is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RG1_out   <= 8'h00;
            RG2_out   <= 8'h00;
            RG3_out   <= 8'h00;
            direccion <= 8'h00;
        end else if (write_strobe && !ocupado) begin
            case (port_id)
                8'h01:   RG1_out   <= out_port;
                8'h02:   RG2_out   <= out_port;
                8'h03:   RG3_out   <= out_port;
                8'h04:   direccion <= out_port;
                default: ;
            endcase
        end
    end

`ifdef ERR_FLAG_EN
    logic cmd_rechazado;
    logic wr_clr;

    // A command is accepted only from REPOSO with exactly one start bit set.
    assign cmd_rechazado = wr_cmd &&
                           !((estado == REPOSO) &&
                             (out_port[1:0] == 2'b01 || out_port[1:0] == 2'b10));
    assign wr_clr        = write_strobe && (port_id == 8'h06);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            error_cmd <= 1'b0;
        else if (wr_clr)
            error_cmd <= 1'b0;
        else if (cmd_rechazado)
            error_cmd <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_deco_salida_picoblaze.sv
// Bench for deco_salida_picoblaze: directed PicoBlaze writes, scoreboard of expected register/flag snapshots and start pulses.
module tb_deco_salida_picoblaze;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write_strobe = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       listo_lee = 1'b0;
    logic       listo_escribe = 1'b0;
    logic [7:0] RG1_out, RG2_out, RG3_out, direccion;
    logic       inicia_lee, inicia_escribe, ocupado;
`ifdef ERR_FLAG_EN
    logic       error_cmd;
`endif

    deco_salida_picoblaze dut (
        .clk           (clk),
        .rst           (rst),
        .write_strobe  (write_strobe),
        .port_id       (port_id),
        .out_port      (out_port),
        .listo_lee     (listo_lee),
        .listo_escribe (listo_escribe),
        .RG1_out       (RG1_out),
        .RG2_out       (RG2_out),
        .RG3_out       (RG3_out),
        .direccion     (direccion),
        .inicia_lee    (inicia_lee),
        .inicia_escribe(inicia_escribe),
        .ocupado       (ocupado)
`ifdef ERR_FLAG_EN
        ,
        .error_cmd     (error_cmd)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         stamp;
        logic [7:0] r1, r2, r3, d;
        logic       ocu, err;
    } exp_t;

    typedef struct packed {
        int   stamp;
        logic is_wr;
    } pul_t;

    exp_t  exp_q[$];
    string nm_q[$];
    pul_t  pul_q[$];
    string pnm_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    done = 1'b0;
    bit    prev_pulse = 1'b0;

    task automatic drive(input logic ws, input logic [7:0] pid, input logic [7:0] dat,
                         input logic ll, input logic le);
        write_strobe  = ws;
        port_id       = pid;
        out_port      = dat;
        listo_lee     = ll;
        listo_escribe = le;
    endtask

    task automatic expect_at(input string nm, input int ofs,
                             input logic [7:0] r1, input logic [7:0] r2,
                             input logic [7:0] r3, input logic [7:0] d,
                             input logic ocu, input logic err);
        exp_t e;
        e.stamp = cyc + ofs;
        e.r1 = r1; e.r2 = r2; e.r3 = r3; e.d = d;
        e.ocu = ocu; e.err = err;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic exp_nxt(input string nm,
                           input logic [7:0] r1, input logic [7:0] r2,
                           input logic [7:0] r3, input logic [7:0] d,
                           input logic ocu, input logic err);
        expect_at(nm, 1, r1, r2, r3, d, ocu, err);
    endtask

    task automatic exp_pulse(input string nm, input logic is_wr);
        pul_t p;
        p.stamp = cyc + 1;
        p.is_wr = is_wr;
        pul_q.push_back(p);
        pnm_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    // Monitor: samples mid-cycle, pops due snapshots and matches every start pulse.
    exp_t       me;
    pul_t       mp;
    string      mnm;
    logic [33:0] act_v, exp_v;
    logic       act_err, exp_err;

    always @(negedge clk) begin
`ifdef ERR_FLAG_EN
        act_err = error_cmd;
`else
        act_err = 1'b0;
`endif
        while (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
            me  = exp_q.pop_front();
            mnm = nm_q.pop_front();
`ifdef ERR_FLAG_EN
            exp_err = me.err;
`else
            exp_err = 1'b0;
`endif
            act_v = {RG1_out, RG2_out, RG3_out, direccion, ocupado, act_err};
            exp_v = {me.r1, me.r2, me.r3, me.d, me.ocu, exp_err};
            checks++;
            if (me.stamp != cyc || act_v !== exp_v) begin
                errors++;
                $display("FAIL %s: rg1/rg2/rg3/dir/ocupado/err got %h %h %h %h %b %b, want %h %h %h %h %b %b (cycle %0d, due %0d)",
                         mnm, RG1_out, RG2_out, RG3_out, direccion, ocupado, act_err,
                         me.r1, me.r2, me.r3, me.d, me.ocu, exp_err, cyc, me.stamp);
            end
        end

        if (inicia_lee || inicia_escribe) begin
            checks++;
            if (pul_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got inicia_lee=%b inicia_escribe=%b, want no pulse (cycle %0d)",
                         inicia_lee, inicia_escribe, cyc);
            end else begin
                mp  = pul_q.pop_front();
                mnm = pnm_q.pop_front();
                if (mp.stamp != cyc || inicia_lee !== ~mp.is_wr || inicia_escribe !== mp.is_wr) begin
                    errors++;
                    $display("FAIL %s: got inicia_lee=%b inicia_escribe=%b at cycle %0d, want lee=%b escribe=%b at cycle %0d",
                             mnm, inicia_lee, inicia_escribe, cyc, ~mp.is_wr, mp.is_wr, mp.stamp);
                end
            end
            checks++;
            if (prev_pulse) begin
                errors++;
                $display("FAIL back_to_back_pulse: got start pulse in two consecutive cycles, want single-cycle (cycle %0d)", cyc);
            end
        end
        prev_pulse = inicia_lee || inicia_escribe;

        while (pul_q.size() > 0 && pul_q[0].stamp < cyc) begin
            mp  = pul_q.pop_front();
            mnm = pnm_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: got no start pulse, want %s pulse at cycle %0d",
                     mnm, mp.is_wr ? "inicia_escribe" : "inicia_lee", mp.stamp);
        end

        if (done) begin
            checks++;
            if (exp_q.size() != 0 || pul_q.size() != 0) begin
                errors++;
                $display("FAIL leftover_expectations: got %0d snapshots and %0d pulses unchecked, want 0 and 0",
                         exp_q.size(), pul_q.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, want completion within 200000 time units");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect_at("reset_hold", 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();

        // Register loads
        drive(1'b1, 8'h01, 8'h15, 1'b0, 1'b0); exp_nxt("wr_rg1", 8'h15, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); step();
        drive(1'b1, 8'h02, 8'h30, 1'b0, 1'b0); exp_nxt("wr_rg2", 8'h15, 8'h30, 8'h00, 8'h00, 1'b0, 1'b0); step();
        drive(1'b1, 8'h03, 8'h12, 1'b0, 1'b0); exp_nxt("wr_rg3", 8'h15, 8'h30, 8'h12, 8'h00, 1'b0, 1'b0); step();
        drive(1'b1, 8'h04, 8'h21, 1'b0, 1'b0); exp_nxt("wr_dir", 8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b0); step();

        // Ignored writes
        drive(1'b0, 8'h01, 8'h99, 1'b0, 1'b0); exp_nxt("no_strobe", 8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b0); step();
        drive(1'b1, 8'h07, 8'hAA, 1'b0, 1'b0); exp_nxt("bad_port",  8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b0); step();
        drive(1'b1, 8'h06, 8'h00, 1'b0, 1'b0); exp_nxt("clr_idle",  8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b0); step();

        // Write transaction with writes/commands while busy
        drive(1'b1, 8'h05, 8'h02, 1'b0, 1'b0); exp_pulse("start_wr", 1'b1);
        exp_nxt("cmd_wr",     8'h15, 8'h30, 8'h12, 8'h21, 1'b1, 1'b0); step();
        drive(1'b1, 8'h01, 8'hFF, 1'b0, 1'b0); exp_nxt("busy_rg1",   8'h15, 8'h30, 8'h12, 8'h21, 1'b1, 1'b0); step();
        drive(1'b1, 8'h04, 8'h55, 1'b0, 1'b0); exp_nxt("busy_dir",   8'h15, 8'h30, 8'h12, 8'h21, 1'b1, 1'b0); step();
        drive(1'b1, 8'h05, 8'h01, 1'b0, 1'b0); exp_nxt("busy_cmd",   8'h15, 8'h30, 8'h12, 8'h21, 1'b1, 1'b1); step();
        drive(1'b1, 8'h06, 8'h00, 1'b0, 1'b0); exp_nxt("clr_busy",   8'h15, 8'h30, 8'h12, 8'h21, 1'b1, 1'b0); step();
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0); exp_nxt("wrong_done", 8'h15, 8'h30, 8'h12, 8'h21, 1'b1, 1'b0); step();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1); exp_nxt("done_wr",    8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b0); step();

        // Read transaction, mismatched done ignored, done pulses in idle ignored
        drive(1'b1, 8'h05, 8'h01, 1'b0, 1'b0); exp_pulse("start_rd", 1'b0);
        exp_nxt("cmd_rd",    8'h15, 8'h30, 8'h12, 8'h21, 1'b1, 1'b0); step();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1); exp_nxt("rd_ign_le", 8'h15, 8'h30, 8'h12, 8'h21, 1'b1, 1'b0); step();
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0); exp_nxt("done_rd",   8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b0); step();
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0); exp_nxt("idle_ll",   8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b0); step();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1); exp_nxt("idle_le",   8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b0); step();

        // Invalid command encodings, upper command bits ignored
        drive(1'b1, 8'h05, 8'h03, 1'b0, 1'b0); exp_nxt("cmd_both", 8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b1); step();
        drive(1'b1, 8'h06, 8'h00, 1'b0, 1'b0); exp_nxt("clr_err",  8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b0); step();
        drive(1'b1, 8'h05, 8'hFC, 1'b0, 1'b0); exp_nxt("cmd_none", 8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b1); step();
        drive(1'b1, 8'h05, 8'hFE, 1'b0, 1'b0); exp_pulse("start_wr_hi", 1'b1);
        exp_nxt("cmd_wr_hi", 8'h15, 8'h30, 8'h12, 8'h21, 1'b1, 1'b1); step();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1); exp_nxt("done_wr2", 8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b1); step();
        drive(1'b1, 8'h06, 8'h00, 1'b0, 1'b0); exp_nxt("clr_err2", 8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b0); step();

        // Done pulse and new command in the same cycle, then retry
        drive(1'b1, 8'h05, 8'h01, 1'b0, 1'b0); exp_pulse("start_rd2", 1'b0);
        exp_nxt("cmd_rd2",      8'h15, 8'h30, 8'h12, 8'h21, 1'b1, 1'b0); step();
        drive(1'b1, 8'h05, 8'h02, 1'b1, 1'b0); exp_nxt("done_and_cmd", 8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b1); step();
        drive(1'b1, 8'h05, 8'h02, 1'b0, 1'b0); exp_pulse("retry_wr", 1'b1);
        exp_nxt("retry_wr",     8'h15, 8'h30, 8'h12, 8'h21, 1'b1, 1'b1); step();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1); exp_nxt("done_wr3",  8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b1); step();

        // Reset mid-read, late done pulse ignored
        drive(1'b1, 8'h06, 8'h00, 1'b0, 1'b0); exp_nxt("clr_err3",       8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b0); step();
        drive(1'b1, 8'h05, 8'h03, 1'b0, 1'b0); exp_nxt("err_before_rst", 8'h15, 8'h30, 8'h12, 8'h21, 1'b0, 1'b1); step();
        drive(1'b1, 8'h05, 8'h01, 1'b0, 1'b0); exp_pulse("start_rd3", 1'b0);
        exp_nxt("cmd_rd3", 8'h15, 8'h30, 8'h12, 8'h21, 1'b1, 1'b1); step();
        step();
        rst = 1'b1;
        expect_at("rst_async", 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0); exp_nxt("late_ll",   8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); step();
        drive(1'b1, 8'h01, 8'h5A, 1'b0, 1'b0); exp_nxt("after_rst", 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); step();

        step();
        step();
        done = 1'b1;
    end

endmodule
